// File: rtl/qpsk_symbol_mapper.sv
// QPSK transmit symbol mapper: dibit in over valid/ready, held for SPS cycles as +/-AMP I/Q levels.
// Define QPSK_DIFF_ENC_EN to enable differential (DQPSK, Gray-coded) encoding.
module qpsk_symbol_mapper #(
  parameter int SPS   = 8,
  parameter int OUT_W = 19,
  parameter int AMP   = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_bits,
  output logic             in_ready,
  output logic [OUT_W-1:0] I_out,
  output logic [OUT_W-1:0] Q_out,
  output logic             out_valid,
  output logic             sym_strobe,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0]               LAST  = 8'(SPS - 1);
  localparam logic signed [OUT_W-1:0]  LVL_P = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0]  LVL_N = -LVL_P;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic                    hold_full_q;
  logic [1:0]              hold_bits_q;
  logic signed [OUT_W-1:0] i_q, q_q;
  logic                    vld_q, stb_q;

  logic                    xfer;
  logic                    last;
  logic                    load_d;
  logic [1:0]              load_bits_d;
  logic                    sgn_i_d, sgn_q_d;

  function automatic logic signed [OUT_W-1:0] level(input logic pos);
    return pos ? LVL_P : LVL_N;
  endfunction

  assign in_ready   = (state_q == IDLE) || !hold_full_q;
  assign xfer       = in_valid && in_ready;
  assign last       = (state_q == RUN) && (cnt_q == LAST);
  assign busy       = (state_q == RUN) || hold_full_q;
  assign I_out      = i_q;
  assign Q_out      = q_q;
  assign out_valid  = vld_q;
  assign sym_strobe = stb_q;

  // A symbol is loaded on accept in IDLE, or at the last sample from the holding register
  // (preferred) or straight from the input when the holding register is empty.
  always_comb begin
    load_d      = 1'b0;
    load_bits_d = in_bits;
    if (state_q == IDLE) begin
      load_d = xfer;
    end else if (cnt_q == LAST) begin
      if (hold_full_q) begin
        load_d      = 1'b1;
        load_bits_d = hold_bits_q;
      end else begin
        load_d = xfer;
      end
    end
  end

`ifdef QPSK_DIFF_ENC_EN
  logic [1:0] phase_q, phase_d;

  function automatic logic [1:0] gray_inc(input logic [1:0] b);
    case (b)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign phase_d = phase_q + gray_inc(load_bits_d);
  assign sgn_i_d = (phase_d == 2'd0) || (phase_d == 2'd3);
  assign sgn_q_d = (phase_d == 2'd0) || (phase_d == 2'd1);

  // Phase survives IDLE; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)         phase_q <= 2'd0;
    else if (load_d) phase_q <= phase_d;
  end
`else
  assign sgn_i_d = load_bits_d[1];
  assign sgn_q_d = load_bits_d[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      hold_full_q <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      vld_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      stb_q <= load_d;
      if (load_d) begin
        state_q <= RUN;
        cnt_q   <= 8'd0;
        i_q     <= level(sgn_i_d);
        q_q     <= level(sgn_q_d);
        vld_q   <= 1'b1;
      end else if (state_q == RUN) begin
        if (cnt_q == LAST) begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          i_q     <= '0;
          q_q     <= '0;
          vld_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      if ((state_q == RUN) && !last && xfer) begin
        hold_full_q <= 1'b1;
      end else if (last && hold_full_q) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // Holding data needs no reset; its validity is tracked by hold_full_q.
  always_ff @(posedge clk) begin
    if ((state_q == RUN) && !last && xfer) hold_bits_q <= in_bits;
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Self-checking bench for qpsk_symbol_mapper (SPS=4) against a symbol-queue reference model.
module tb_qpsk_symbol_mapper;
  localparam int SPS   = 4;
  localparam int OUT_W = 19;
  localparam int AMP   = 65536;
  localparam int VW    = 4 + 2 * OUT_W;
  localparam logic signed [OUT_W-1:0] PAMP = 19'sd65536;
  localparam logic signed [OUT_W-1:0] NAMP = -19'sd65536;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] in_bits = 2'b00;
  logic in_ready, out_valid, sym_strobe, busy;
  logic [OUT_W-1:0] I_out, Q_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples left in the current symbol plus a queue of waiting dibits.
  logic [1:0] pend[$];
  int left  = 0;
  int phase = 0;
  logic signed [OUT_W-1:0] cur_i = '0;
  logic signed [OUT_W-1:0] cur_q = '0;

  always #5 clk = ~clk;

  qpsk_symbol_mapper #(.SPS(SPS), .OUT_W(OUT_W), .AMP(AMP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .I_out(I_out), .Q_out(Q_out), .out_valid(out_valid), .sym_strobe(sym_strobe), .busy(busy)
  );

  function automatic logic m_ready();
    return (left == 0) || (pend.size() == 0);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic on;
    logic [OUT_W-1:0] ei, eq;
    on = (left > 0);
    ei = on ? cur_i : '0;
    eq = on ? cur_q : '0;
    return {m_ready(), on, (left == SPS), on || (pend.size() > 0), ei, eq};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {in_ready, out_valid, sym_strobe, busy, I_out, Q_out};
  endfunction

  task automatic m_start(input logic [1:0] b);
`ifdef QPSK_DIFF_ENC_EN
    int inc_tab[4] = '{0, 1, 3, 2};
    phase = (phase + inc_tab[b]) % 4;
    cur_i = (phase == 0 || phase == 3) ? PAMP : NAMP;
    cur_q = (phase == 0 || phase == 1) ? PAMP : NAMP;
`else
    cur_i = b[1] ? PAMP : NAMP;
    cur_q = b[0] ? PAMP : NAMP;
`endif
    left = SPS;
  endtask

  // Drive one cycle, advance the model at the edge, return at the following negedge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] b, output logic acc);
    rst = r;
    in_valid = v;
    in_bits = b;
    acc = !r && v && m_ready();
    @(posedge clk);
    if (r) begin
      pend.delete();
      left = 0;
      phase = 0;
    end else if (left == 0) begin
      if (acc) m_start(b);
    end else if (left == 1) begin
      if (pend.size() > 0) m_start(pend.pop_front());
      else if (acc) m_start(b);
      else left = 0;
    end else begin
      left--;
      if (acc) pend.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    cyc(1'b1, 1'b0, 2'b00, acc);
    cyc(1'b1, 1'b0, 2'b00, acc);
    n_tests++;
    if (dut_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, {(2*OUT_W){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), {1'b1, 3'b000, {(2*OUT_W){1'b0}}});
    end
    cyc(1'b0, 1'b0, 2'b00, acc);
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    logic acc;
    int nv, ns;
    nv = 0; ns = 0;
    cyc(1'b1, 1'b0, 2'b00, acc);
    cyc(1'b0, 1'b1, 2'b10, acc);
    n_tests++;
    if (I_out !== PAMP || Q_out !== NAMP || out_valid !== 1'b1 || sym_strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first: got I=%0d Q=%0d v=%b s=%b want I=65536 Q=-65536 v=1 s=1",
               $signed(I_out), $signed(Q_out), out_valid, sym_strobe);
    end
    nv += out_valid; ns += sym_strobe;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 2'b00, acc);
      nv += out_valid; ns += sym_strobe;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_cyc%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    n_tests++;
    if (nv != 4 || ns != 1) begin
      n_fail++;
      $display("FAIL single_len: got valid=%0d strobe=%0d want valid=4 strobe=1", nv, ns);
    end
    n_tests++;
    if (I_out !== '0 || Q_out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got I=%0d Q=%0d v=%b want 0 0 0", $signed(I_out), $signed(Q_out), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [1:0] seq[4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    logic signed [OUT_W-1:0] ei[4] = '{PAMP, NAMP, NAMP, PAMP};
    logic signed [OUT_W-1:0] eq[4] = '{PAMP, NAMP, PAMP, NAMP};
    int idx, nv, ns, sidx, saw_nready;
    idx = 0; nv = 0; ns = 0; sidx = 0; saw_nready = 0;
    cyc(1'b1, 1'b0, 2'b00, acc);
    for (int k = 0; k < 24; k++) begin
      if (idx < 4) cyc(1'b0, 1'b1, seq[idx], acc);
      else cyc(1'b0, 1'b0, 2'b00, acc);
      if (acc) idx++;
      if (!in_ready) saw_nready++;
      nv += out_valid;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
      if (sym_strobe) begin
`ifndef QPSK_DIFF_ENC_EN
        n_tests++;
        if (sidx < 4 && (I_out !== ei[sidx] || Q_out !== eq[sidx])) begin
          n_fail++;
          $display("FAIL b2b_level%0d: got I=%0d Q=%0d want I=%0d Q=%0d", sidx,
                   $signed(I_out), $signed(Q_out), ei[sidx], eq[sidx]);
        end
`endif
        sidx++;
        ns++;
      end
    end
    n_tests++;
    if (nv != 16 || ns != 4 || saw_nready == 0) begin
      n_fail++;
      $display("FAIL b2b_stream: got valid=%0d strobes=%0d nready=%0d want 16 4 >0", nv, ns, saw_nready);
    end
  endtask

  task automatic test_late_arrival();
    logic acc;
    for (int gap = 3; gap <= 4; gap++) begin
      cyc(1'b1, 1'b0, 2'b00, acc);
      cyc(1'b0, 1'b1, 2'b01, acc);
      for (int k = 0; k < gap; k++) cyc(1'b0, 1'b0, 2'b00, acc);
      if (gap == 4) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL late_gap: got out_valid=%b want 0", out_valid);
        end
      end
      cyc(1'b0, 1'b1, 2'b10, acc);
      n_tests++;
      if (out_valid !== 1'b1 || sym_strobe !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL late_load_gap%0d: got %h want %h", gap, dut_vec(), exp_vec());
      end
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, 1'b0, 2'b00, acc);
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL late_tail%0d_%0d: got %h want %h", gap, k, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int nv;
    nv = 0;
    cyc(1'b1, 1'b0, 2'b00, acc);
    cyc(1'b0, 1'b1, 2'b11, acc);
    cyc(1'b0, 1'b1, 2'b00, acc);
    cyc(1'b0, 1'b0, 2'b00, acc);
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_pre: got busy=%b ready=%b want 1 0", busy, in_ready);
    end
    cyc(1'b1, 1'b0, 2'b00, acc);
    n_tests++;
    if (dut_vec() !== {1'b1, 3'b000, {(2*OUT_W){1'b0}}}) begin
      n_fail++;
      $display("FAIL rstmid_post: got %h want %h", dut_vec(), {1'b1, 3'b000, {(2*OUT_W){1'b0}}});
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 2'b00, acc);
      nv += out_valid;
    end
    n_tests++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rstmid_discard: got %0d valid cycles want 0", nv);
    end
  endtask

  task automatic test_diff();
`ifdef QPSK_DIFF_ENC_EN
    logic acc;
    logic [1:0] seq[4] = '{2'b01, 2'b01, 2'b11, 2'b00};
    logic signed [OUT_W-1:0] ei[4] = '{NAMP, NAMP, PAMP, PAMP};
    logic signed [OUT_W-1:0] eq[4] = '{PAMP, NAMP, PAMP, PAMP};
    int idx, sidx;
    idx = 0; sidx = 0;
    cyc(1'b1, 1'b0, 2'b00, acc);
    for (int k = 0; k < 20; k++) begin
      if (idx < 4) cyc(1'b0, 1'b1, seq[idx], acc);
      else cyc(1'b0, 1'b0, 2'b00, acc);
      if (acc) idx++;
      if (sym_strobe && sidx < 4) begin
        n_tests++;
        if (I_out !== ei[sidx] || Q_out !== eq[sidx]) begin
          n_fail++;
          $display("FAIL diff_sym%0d: got I=%0d Q=%0d want I=%0d Q=%0d", sidx,
                   $signed(I_out), $signed(Q_out), ei[sidx], eq[sidx]);
        end
        sidx++;
      end
    end
    n_tests++;
    if (sidx != 4) begin
      n_fail++;
      $display("FAIL diff_count: got %0d symbols want 4", sidx);
    end
`endif
  endtask

  task automatic test_random();
    logic acc, v, r;
    logic [1:0] b;
    logic hold;
    hold = 1'b0; b = 2'b00;
    cyc(1'b1, 1'b0, 2'b00, acc);
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 63) == 0);
      if (hold) v = 1'b1;
      else begin
        v = ($urandom_range(0, 9) < 6);
        b = 2'($urandom_range(0, 3));
      end
      cyc(r, v, b, acc);
      hold = v && !acc && !r;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_late_arrival();
    test_reset_mid();
    test_diff();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qpsk_symbol_mapper.md
Name: qpsk_symbol_mapper

Overview:
- Transmit-side counterpart of the QPSK integrate-and-dump slicer.
- Accepts one dibit per symbol over a valid/ready handshake and maps it to signed I/Q levels of ±AMP.
- Holds each symbol for SPS clock cycles, giving a rectangular pulse train that the downstream TX filter and DAC path consume at sample rate.
- One internal holding register lets the producer run ahead by one symbol, so back-to-back symbols leave no gap.

Parameters:
- SPS, 8, samples per symbol (clock cycles per symbol); legal range 2..256.
- OUT_W, 19, width of the signed I/Q outputs; matches the receive filter input width.
- AMP, 65536, magnitude of the output level; must satisfy AMP <= 2^(OUT_W-1)-1.

Ports:
- clk  input  1  sample clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dibit on in_bits is valid.
- in_bits  input  2  symbol dibit; [1] selects I sign, [0] selects Q sign.
- in_ready  output  1  block can accept a dibit this cycle.
- I_out  output  OUT_W  signed I sample.
- Q_out  output  OUT_W  signed Q sample.
- out_valid  output  1  I_out/Q_out carry an active symbol sample.
- sym_strobe  output  1  high on the first sample cycle of each symbol.
- busy  output  1  state is RUN or the holding register is full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, sample counter cnt=0, holding register empty.
  - I_out=0, Q_out=0, out_valid=0, sym_strobe=0, busy=0.
  - DQPSK phase (when enabled) = 0.
  - A reset mid-symbol discards the current symbol and the holding register contents.
- Handshake: a transfer occurs when in_valid && in_ready at a rising edge. in_bits must stay stable while in_valid=1 and in_ready=0.
- Direct mapping: bit=1 -> +AMP, bit=0 -> -AMP, independently for I (in_bits[1]) and Q (in_bits[0]). Values are sign-extended to OUT_W.
- IDLE state:
  - in_ready=1, out_valid=0, I_out=Q_out=0.
  - On a transfer at edge N: from N+1, I_out/Q_out hold the mapped symbol, out_valid=1, sym_strobe=1, cnt=0, state=RUN.
  - Latency from accept to first sample is 1 cycle.
- RUN state:
  - cnt increments each clock. in_ready = holding register empty.
  - A transfer while cnt<SPS-1 fills the holding register.
  - At the edge where cnt==SPS-1:
    - Holding register full: load it into the outputs, empty it, cnt=0, pulse sym_strobe.
    - Holding register empty and a transfer occurs on this same edge: load the input directly into the outputs, cnt=0, pulse sym_strobe.
    - Otherwise: go to IDLE and drive outputs to 0 with out_valid=0 on the next cycle.
- Each symbol occupies exactly SPS consecutive cycles with out_valid=1. sym_strobe is high only on its first cycle.
- Throughput: one dibit per SPS cycles sustained with no idle cycles between symbols.
- The holding register holds one entry only. A new transfer can never overwrite it, because in_ready=0 while it is full.
- cnt wraps from SPS-1 to 0. cnt is wide enough for SPS=256 (8 bits, holding 0..255).

Optional Feature:
- Macro: QPSK_DIFF_ENC_EN.
- Defined: differential (DQPSK) encoding.
  - Phase increment from the dibit, Gray coded: 00->+0, 01->+1, 11->+2, 10->+3 (quarter turns).
  - Phase update: phase = (phase + inc) mod 4, applied at each symbol load.
  - Phase to outputs: 0->(+AMP,+AMP), 1->(-AMP,+AMP), 2->(-AMP,-AMP), 3->(+AMP,-AMP).
  - Phase is cleared only by rst and persists across IDLE.
- Not defined: direct mapping as above, with no phase state.

Test Plan:
- Reset: SPS=4, OUT_W=19, AMP=65536; assert rst for 2 cycles -> all outputs 0, in_ready=1 on the first cycle after rst deasserts.
- Single symbol: send dibit 10 in IDLE -> on the next cycle I_out=+65536, Q_out=-65536, out_valid=1 for exactly 4 cycles with sym_strobe only on the first; then out_valid=0 and I_out=Q_out=0.
- Back-to-back stream: keep in_valid=1 with dibits 11,00,01,10 -> 16 contiguous valid cycles, sym_strobe every 4th cycle, levels (+,+),(-,-),(-,+),(+,-); in_ready is low while the holding register is full.
- Late arrival: the second dibit arrives exactly on the cnt==3 edge with the holding register empty -> it is loaded directly with no gap. If it arrives one cycle later, there is one IDLE cycle with out_valid=0.
- Reset mid-symbol: assert rst at cnt=2 with the holding register full -> the next cycle shows outputs 0 and busy=0, and the held dibit is never emitted.
- QPSK_DIFF_ENC_EN: dibits 01,01,11,00 from reset -> phases 1,2,0,0 -> (-,+),(-,-),(+,+),(+,+).
